pll_lock_sequencer: RTL
=======================

// Module: pll_lock_sequencer
// PURPOSE
//  Sequences the system PLL after power-up or on request. Pulses the PLL reset,
//  waits for lock with a timeout, and qualifies lock as stable for a minimum time.
//  Holds the downstream system reset until the PLL outputs are usable.
//  Retries a bounded number of times before flagging a fault.
//  Sits in sys/ beside the PLL wrapper, clocked from the 50 MHz reference clock.
// PARAMETERS
//  RST_PULSE_CYC    16      refclk cycles pll_rst is held high per attempt
//  LOCK_TIMEOUT_CYC 500000  max cycles in WAIT_LOCK before the attempt fails (10 ms)
//  LOCK_STABLE_CYC  1024    cycles locked_s must stay high continuously before release
//  OUT_RST_CYC      64      extra cycles sys_rst is held after stable lock
//  MAX_RETRIES      3       failed attempts tolerated; attempt MAX_RETRIES+1 failing -> FAULT
// PORTS
//  refclk      in   1   single clock, 50 MHz PLL reference
//  rst         in   1   synchronous, active-high block reset
//  pll_locked  in   1   PLL locked output, asynchronous to refclk
//  restart     in   1   one-cycle request to re-run the full sequence (e.g. after reconfig)
//  pll_rst     out  1   drives the PLL rst input
//  sys_rst     out  1   registered active-high reset for logic on the PLL output clocks
//  ready       out  1   1 only in RUN
//  fault       out  1   1 only in FAULT
//  retries     out  2   failed attempts since last rst/restart, saturating at MAX_RETRIES
// BEHAVIOUR
//  - Sync: pll_locked passes a 2-FF synchroniser -> locked_s; all decisions use locked_s.
//  - rst=1 at an edge: state=PULSE, cnt=0, retries=0, pll_rst=1, sys_rst=1, ready=0, fault=0,
//    synchroniser cleared. rst dominates restart and everything else.
//  - PULSE: pll_rst=1 for exactly RST_PULSE_CYC cycles, then -> WAIT_LOCK with cnt=0.
//  - WAIT_LOCK: pll_rst=0. locked_s=1 -> STABLE, cnt=0.
//    cnt reaches LOCK_TIMEOUT_CYC-1 without lock -> attempt fails.
//  - STABLE: locked_s=0 -> attempt fails. LOCK_STABLE_CYC consecutive highs -> RELEASE, cnt=0.
//  - Attempt fails: if retries==MAX_RETRIES -> FAULT; otherwise retries+1 and -> PULSE.
//  - RELEASE: sys_rst stays 1 for OUT_RST_CYC cycles, then -> RUN.
//    locked_s=0 during RELEASE -> attempt fails.
//  - RUN: sys_rst=0, ready=1. locked_s=0 -> PULSE next cycle with sys_rst=1 and ready=0
//    registered at that edge; retries reset to 0, since a lock loss in RUN is not a failure.
//  - FAULT: pll_rst=0, sys_rst=1, fault=1. Terminal until rst or restart.
//  - restart=1 in any state (rst=0): -> PULSE, cnt=0, retries=0, sys_rst=1, ready=0, fault=0.
//    Same effect as rst except the synchroniser is kept.
//  - sys_rst is 1 in every state except RUN. ready and sys_rst are never both 1 or both 0.
//  - Counter: single shared cnt, width clog2 of the largest cycle parameter; cleared on
//    every state entry. No wrap: terminal compare happens before overflow.
//  - Latency, locked rising at the pin to sys_rst falling (ideal PLL):
//    2 (sync) + 1 + LOCK_STABLE_CYC + OUT_RST_CYC cycles.
//  - All outputs are registered; none is combinational from inputs.
// STRUCTURE
//  - Shared sys package: state enum {PULSE, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT}
//    (3-bit encoding) and the default cycle constants.
//  - One sub-module: sync_2ff (generic 2-flop synchroniser, reset to 0), reused for pll_locked.
//  - Everything else is one FSM process plus the counter in this module.
// TESTING
//  1. rst for 2 cycles; model PLL locks 100 cycles after pll_rst falls -> pll_rst high exactly
//     16 cycles; sys_rst falls at 16+100+3+1024+64 (+/-1) after rst release; ready rises same edge.
//  2. PLL never locks -> 4 pulses of pll_rst, each 500000 cycles apart; retries reads 1,2,3;
//     then fault=1, sys_rst=1, pll_rst=0 indefinitely.
//  3. Lock glitches low for 1 cycle at STABLE cycle 500 -> new PULSE, retries=1; second attempt
//     clean -> RUN with retries=1.
//  4. In RUN, drop pll_locked for 10 cycles -> sys_rst=1 and ready=0 within 4 cycles;
//     pll_rst pulses 16 cycles; retries=0; full relock sequence returns to RUN.
//  5. In FAULT, pulse restart -> fault=0 next edge, pll_rst high for 16 cycles, retries=0;
//     PLL locks -> RUN.
//  6. rst asserted while in RELEASE and again while restart=1 -> state PULSE, all outputs at
//     reset values the next edge; restart ignored while rst=1.

Source files
------------

// File: rtl/pll_lock_sequencer_pkg.sv
// Shared definitions for the PLL lock sequencer: FSM state encoding, default
// cycle constants and a helper for sizing the shared cycle counter.
package pll_lock_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_PULSE     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    localparam int DEF_RST_PULSE_CYC    = 16;
    localparam int DEF_LOCK_TIMEOUT_CYC = 500000;
    localparam int DEF_LOCK_STABLE_CYC  = 1024;
    localparam int DEF_OUT_RST_CYC      = 64;
    localparam int DEF_MAX_RETRIES      = 3;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Generic two-flop synchroniser with synchronous clear, one chain per bit.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_ff @(posedge clk) begin
                if (srst) begin
                    meta_reg[gi] <= 1'b0;
                    sync_reg[gi] <= 1'b0;
                end else begin
                    meta_reg[gi] <= d[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign q = sync_reg;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Power-up / restart sequencer for the system PLL: pulses pll_rst, waits for a
// qualified lock with timeout and bounded retries, then releases sys_rst.
module pll_lock_sequencer
    import pll_lock_sequencer_pkg::*;
#(
    parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int OUT_RST_CYC      = DEF_OUT_RST_CYC,
    parameter int MAX_RETRIES      = DEF_MAX_RETRIES
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retries
);

    localparam int CNT_MAX_CYC = max_of4(RST_PULSE_CYC, LOCK_TIMEOUT_CYC,
                                         LOCK_STABLE_CYC, OUT_RST_CYC);
    localparam int CNT_W = (CNT_MAX_CYC > 1) ? $clog2(CNT_MAX_CYC) : 1;

    // Terminal counts: each phase ends when cnt hits N-1, so cnt never wraps.
    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] OUT_LAST     = CNT_W'(OUT_RST_CYC - 1);
    localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       retries_reg, retries_next;
    logic             attempt_fail;
    logic             locked_s;
    logic             pll_rst_reg, pll_rst_next;
    logic             sys_rst_reg, sys_rst_next;
    logic             ready_reg, ready_next;
    logic             fault_reg, fault_next;

    sync_2ff #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk (refclk),
        .srst(rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_reg   <= ST_PULSE;
            cnt_reg     <= '0;
            retries_reg <= '0;
            pll_rst_reg <= 1'b1;
            sys_rst_reg <= 1'b1;
            ready_reg   <= 1'b0;
            fault_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            retries_reg <= retries_next;
            pll_rst_reg <= pll_rst_next;
            sys_rst_reg <= sys_rst_next;
            ready_reg   <= ready_next;
            fault_reg   <= fault_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg + CNT_W'(1);
        retries_next = retries_reg;
        attempt_fail = 1'b0;
        case (state_reg)
            ST_PULSE: begin
                if (cnt_reg == PULSE_LAST) begin
                    state_next = ST_WAIT_LOCK;
                    cnt_next   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_next = ST_STABLE;
                    cnt_next   = '0;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    attempt_fail = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    attempt_fail = 1'b1;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next = ST_RELEASE;
                    cnt_next   = '0;
                end
            end
            ST_RELEASE: begin
                if (!locked_s) begin
                    attempt_fail = 1'b1;
                end else if (cnt_reg == OUT_LAST) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end
            end
            ST_RUN: begin
                cnt_next = '0;
                // Losing lock after a good run starts a fresh sequence, not a retry.
                if (!locked_s) begin
                    state_next   = ST_PULSE;
                    retries_next = '0;
                end
            end
            ST_FAULT: begin
                cnt_next = '0;
            end
            default: begin
                state_next = ST_PULSE;
                cnt_next   = '0;
            end
        endcase

        if (attempt_fail) begin
            cnt_next = '0;
            if (retries_reg == RETRY_LIMIT) begin
                state_next = ST_FAULT;
            end else begin
                state_next   = ST_PULSE;
                retries_next = retries_reg + 2'd1;
            end
        end

        if (restart) begin
            state_next   = ST_PULSE;
            cnt_next     = '0;
            retries_next = '0;
        end
    end

    // Outputs decode the state being entered, so they register on the same edge.
    always_comb begin
        pll_rst_next = (state_next == ST_PULSE);
        sys_rst_next = (state_next != ST_RUN);
        ready_next   = (state_next == ST_RUN);
        fault_next   = (state_next == ST_FAULT);
    end

    assign pll_rst = pll_rst_reg;
    assign sys_rst = sys_rst_reg;
    assign ready   = ready_reg;
    assign fault   = fault_reg;
    assign retries = retries_reg;

endmodule
